vga_grid_renderer: RTL and testbench

// - Parametrised VGA tile renderer: generates 640x480-class timing and paints a GRID_COLS x GRID_ROWS grid of CELL_SIZE-pixel square cells.
// - Each cell holds a palette index in an internal tile RAM, written by the game/CPU logic; a movable cursor cell is drawn inverted.
// - Sits between game-state logic and the DE2-115 VGA DAC; replaces the single fixed-box renderer.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen.sv | 63 ++++++
 rtl/vga_grid_renderer.sv | 124 ++++++++++++
 tb/tb_vga_grid_renderer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing, derived totals and sync windows, the 4-entry palette
// and the palette index type shared by the grid renderer.
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    typedef logic [1:0]  palette_idx_t;
    typedef logic [23:0] rgb_t;

    // Colours packed as {b,g,r}.
    localparam rgb_t PALETTE_BLACK = 24'h000000;
    localparam rgb_t PALETTE_WHITE = 24'hFFFFFF;
    localparam rgb_t PALETTE_RED   = 24'h0000FF;
    localparam rgb_t PALETTE_GREEN = 24'h00FF00;

    function automatic rgb_t palette_lookup(input palette_idx_t idx);
        return idx == 2'd1 ? PALETTE_WHITE :
               idx == 2'd2 ? PALETTE_RED   :
               idx == 2'd3 ? PALETTE_GREEN : PALETTE_BLACK;
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters with sync/active decode and cell position
// tracked incrementally, so no divider is needed to find the current cell.
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int H_SYNC_END   = VGA_H_SYNC_END,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int V_SYNC_END   = VGA_V_SYNC_END,
    parameter int CELL_SIZE    = 10,
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL),
    localparam int PW = $clog2(CELL_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] cx,
    output logic [VW-1:0] cy,
    output logic          hs_c,
    output logic          vs_c,
    output logic          active,
    output logic          frame_start
);
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [PW-1:0] px;
    logic [PW-1:0] py;
    logic          h_end;
    logic          v_end;
    logic          px_end;
    logic          py_end;

    assign h_end       = h == HW'(H_TOTAL - 1);
    assign v_end       = v == VW'(V_TOTAL - 1);
    assign px_end      = px == PW'(CELL_SIZE - 1);
    assign py_end      = py == PW'(CELL_SIZE - 1);
    assign hs_c        = !(h >= HW'(H_SYNC_START) && h < HW'(H_SYNC_END));
    assign vs_c        = !(v >= VW'(V_SYNC_START) && v < VW'(V_SYNC_END));
    assign active      = h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
    assign frame_start = h == '0 && v == '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h  <= '0;
            v  <= '0;
            px <= '0;
            py <= '0;
            cx <= '0;
            cy <= '0;
        end else begin
            h  <= h_end ? '0 : h + 1'b1;
            px <= (h_end || px_end) ? '0 : px + 1'b1;
            cx <= h_end ? '0 : px_end ? cx + 1'b1 : cx;
            if (h_end) begin
                v  <= v_end ? '0 : v + 1'b1;
                py <= (v_end || py_end) ? '0 : py + 1'b1;
                cy <= v_end ? '0 : py_end ? cy + 1'b1 : cy;
            end
        end
    end
endmodule

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: VGA tile renderer painting a grid of palette-indexed cells from an
// internal tile RAM, with an inverted cursor cell; counters to pins in two pipeline stages.
module vga_grid_renderer import vga_pkg::*; #(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int CELL_SIZE = 10,
    parameter int GRID_COLS = 64,
    parameter int GRID_ROWS = 48,
    localparam int CW = $clog2(GRID_COLS),
    localparam int RW = $clog2(GRID_ROWS)
) (
    input  logic          iVGA_CLK,
    input  logic          iRST_n,
    input  logic          iWR_EN,
    input  logic [CW-1:0] iWR_COL,
    input  logic [RW-1:0] iWR_ROW,
    input  logic [1:0]    iWR_IDX,
    input  logic          iCUR_EN,
    input  logic [CW-1:0] iCUR_COL,
    input  logic [RW-1:0] iCUR_ROW,
    output logic          oHS,
    output logic          oVS,
    output logic          oBLANK_n,
    output logic [7:0]    r_data,
    output logic [7:0]    g_data,
    output logic [7:0]    b_data,
    output logic          oFRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = CW + RW;

    logic [HW-1:0] cx;
    logic [VW-1:0] cy;
    logic          hs_c;
    logic          vs_c;
    logic          active;
    logic          frame_start;
    logic          wr_ok;
    logic          in_grid;
    logic          cursor_hit;
    logic [AW-1:0] rd_addr;
    palette_idx_t  ram [2**AW];
    palette_idx_t  idx1;
    logic          hs1;
    logic          vs1;
    logic          act1;
    logic          fs1;
    logic          grid1;
    logic          cur1;
    rgb_t          colour;
    rgb_t          pixel;

    vga_timing_gen #(
        .H_ACTIVE     (H_ACTIVE),
        .H_TOTAL      (H_TOTAL),
        .H_SYNC_START (H_ACTIVE + H_FP),
        .H_SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
        .V_ACTIVE     (V_ACTIVE),
        .V_TOTAL      (V_TOTAL),
        .V_SYNC_START (V_ACTIVE + V_FP),
        .V_SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
        .CELL_SIZE    (CELL_SIZE)
    ) u_timing (
        .clk         (iVGA_CLK),
        .rst_n       (iRST_n),
        .cx          (cx),
        .cy          (cy),
        .hs_c        (hs_c),
        .vs_c        (vs_c),
        .active      (active),
        .frame_start (frame_start)
    );

    assign wr_ok      = iWR_EN && 32'(iWR_COL) < GRID_COLS && 32'(iWR_ROW) < GRID_ROWS;
    assign in_grid    = 32'(cx) < GRID_COLS && 32'(cy) < GRID_ROWS;
    assign cursor_hit = iCUR_EN && 32'(cx) == 32'(iCUR_COL) && 32'(cy) == 32'(iCUR_ROW);
    assign rd_addr    = {cy[RW-1:0], cx[CW-1:0]};

    // Read-before-write on a shared cell: the read port sees the old entry this cycle.
    always_ff @(posedge iVGA_CLK) begin
        if (wr_ok) ram[{iWR_ROW, iWR_COL}] <= iWR_IDX;
        idx1 <= ram[rd_addr];
    end

    assign colour = grid1 ? palette_lookup(idx1) : palette_lookup(2'd0);
    assign pixel  = act1 ? colour ^ {24{cur1}} : '0;

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            hs1          <= 1'b1;
            vs1          <= 1'b1;
            act1         <= 1'b0;
            fs1          <= 1'b0;
            grid1        <= 1'b0;
            cur1         <= 1'b0;
            oHS          <= 1'b1;
            oVS          <= 1'b1;
            oBLANK_n     <= 1'b0;
            oFRAME_START <= 1'b0;
            {b_data, g_data, r_data} <= '0;
        end else begin
            hs1          <= hs_c;
            vs1          <= vs_c;
            act1         <= active;
            fs1          <= frame_start;
            grid1        <= in_grid;
            cur1         <= cursor_hit;
            oHS          <= hs1;
            oVS          <= vs1;
            oBLANK_n     <= act1;
            oFRAME_START <= fs1;
            {b_data, g_data, r_data} <= pixel;
        end
    end
endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: randomized scoreboard bench on a shrunken raster; a pixel-level
// reference model predicts every output cycle and a monitor compares two cycles later.
module tb_vga_grid_renderer;
    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int CELL = 3, GC = 12, GR = 7;
    localparam logic [27:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

    typedef struct {
        logic [27:0] o;
        int          x;
        int          y;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_col = '0;
    logic [2:0] wr_row = '0;
    logic [1:0] wr_idx = '0;
    logic       cur_en = 1'b0;
    logic [3:0] cur_col = '0;
    logic [2:0] cur_row = '0;
    logic       hs, vs, blank_n, fs;
    logic [7:0] r, g, b;

    exp_t q[$];
    int   mram [GR][GC];
    int   mh = 0, mv = 0;
    int   n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    vga_grid_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_SIZE(CELL), .GRID_COLS(GC), .GRID_ROWS(GR)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .iWR_EN(wr_en), .iWR_COL(wr_col), .iWR_ROW(wr_row), .iWR_IDX(wr_idx),
        .iCUR_EN(cur_en), .iCUR_COL(cur_col), .iCUR_ROW(cur_row),
        .oHS(hs), .oVS(vs), .oBLANK_n(blank_n),
        .r_data(r), .g_data(g), .b_data(b), .oFRAME_START(fs)
    );

    function automatic logic [23:0] pal(input int i);
        return i == 1 ? 24'hFFFFFF : i == 2 ? 24'h0000FF : i == 3 ? 24'h00FF00 : 24'h000000;
    endfunction

    // Expected pins for raster position (x,y), using the tile map and cursor as they are now.
    function automatic logic [27:0] expect_at(input int x, input int y);
        bit          act = x < HA && y < VA;
        int          cx = x / CELL;
        int          cy = y / CELL;
        logic [23:0] c = (cx < GC && cy < GR) ? pal(mram[cy][cx]) : pal(0);
        if (cur_en && cx == int'(cur_col) && cy == int'(cur_row)) c = ~c;
        return {!(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS),
                act, x == 0 && y == 0, act ? c : 24'h0};
    endfunction

    // Reference model: one expectation per clock edge; a reset edge means the pins show
    // reset values both right after it and one edge later.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            q.push_back('{RST_OUT, -1, -1});
            q.push_back('{RST_OUT, -1, -1});
            mh = 0;
            mv = 0;
        end else begin
            q.push_back('{expect_at(mh, mv), mh, mv});
            mv = (mh == HT - 1) ? (mv + 1) % VT : mv;
            mh = (mh + 1) % HT;
        end
        if (wr_en && int'(wr_col) < GC && int'(wr_row) < GR) mram[wr_row][wr_col] = int'(wr_idx);
    end

    initial forever begin
        exp_t        e;
        logic [27:0] got;
        @(negedge clk);
        if (q.size() > 1) begin
            e   = q.pop_front();
            got = {hs, vs, blank_n, fs, b, g, r};
            n_vec++;
            if (got !== e.o) begin
                n_err++;
                $display("FAIL pixel(%0d,%0d) got %h expected %h", e.x, e.y, got, e.o);
            end
        end
    end

    // mode 0: idle, 1: random writes and cursor moves, 2: write the cell about to be scanned
    task automatic cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (mode == 1) begin
                wr_en  = $urandom_range(2) == 0;
                wr_col = 4'($urandom_range(15));
                wr_row = 3'($urandom_range(7));
                wr_idx = 2'($urandom_range(3));
                if ($urandom_range(40) == 0) begin
                    cur_en  = 1'($urandom_range(1));
                    cur_col = 4'($urandom_range(15));
                    cur_row = 3'($urandom_range(7));
                end
            end else if (mode == 2 && mh < HA && mv < VA && mh / CELL < GC && mv / CELL < GR) begin
                wr_en  = 1'b1;
                wr_col = 4'(mh / CELL);
                wr_row = 3'(mv / CELL);
                wr_idx = 2'(mram[mv / CELL][mh / CELL] + 1);
            end
        end
    endtask

    task automatic write1(input int c, input int rw, input int idx);
        @(negedge clk);
        wr_en  = 1'b1;
        wr_col = 4'(c);
        wr_row = 3'(rw);
        wr_idx = 2'(idx);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        int k;
        for (int rw = 0; rw < GR; rw++)
            for (int c = 0; c < GC; c++) begin
                @(negedge clk);
                wr_en  = 1'b1;
                wr_col = 4'(c);
                wr_row = 3'(rw);
                wr_idx = 2'd0;
            end
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        cycles(FT, 0);
        write1(5, 4, 1);
        cycles(FT, 0);
        cur_en  = 1'b1;
        cur_col = 4'd5;
        cur_row = 3'd4;
        cycles(FT, 0);
        cur_col = 4'd0;
        cur_row = 3'd0;
        cycles(FT, 0);
        write1(13, 2, 2);
        write1(3, 7, 3);
        cycles(FT, 0);
        cur_en = 1'b0;
        cycles(FT, 2);
        cycles(4 * FT, 1);
        k = 0;
        while (!(mh == 30 && mv == 20) && k < 2 * FT) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2 * FT) begin
            n_vec++;
            n_err++;
            $display("FAIL reset_point position never reached within %0d cycles", 2 * FT);
        end
        wr_en = 1'b0;
        rst_n = 1'b0;
        cycles(3, 0);
        rst_n = 1'b1;
        cycles(FT + 500, 1);
        cycles(4, 0);
        n_vec++;
        if (n_vec < 10 * FT) begin
            n_err++;
            $display("FAIL vector_count got %0d required at least %0d", n_vec, 10 * FT);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
